pixel_unpacker: RTL and testbench
=================================

# pixel_unpacker

- Reads packed image lines from the line SRAM and streams them out as a byte-serial R, G, B pixel sequence under valid/ready flow control.
- Each 256-bit SRAM word holds 8 pixels, one 32-bit slot per pixel: byte0=R, byte1=G, byte2=B, byte3=dummy.
- It is the read-side counterpart of the pixel-clock packing buffer that fills that SRAM. Dummy bytes are never emitted.

## Interface
Parameters:
- BASE_ADDR, 9'd0, SRAM word address holding pixels 0..7.
- `SRAM_WIDTH` is the global macro (256); it is not a parameter.

Ports (synchronous, active-high reset):
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- pixel_trigger_i  in  1  level; high = run/hold, low = abort and return to IDLE
- image_width_i  in  12  pixels per line (0..4095); sampled when leaving IDLE
- mem_rd_o  out  1  one-cycle SRAM read strobe
- mem_addr_o  out  9  SRAM word address
- mem_data_i  in  `SRAM_WIDTH`  read data, valid the cycle after mem_rd_o
- pixel_data_o  out  8  output byte
- pixel_valid_o  out  1  byte valid
- pixel_ready_i  in  1  downstream accept
- pixel_trigger_done_o  out  1  line fully streamed; held until trigger drops

## Operation
- States:
  - IDLE, FETCH, WAIT, STREAM, DONE.
- Counters:
  - Pixel index p, 12 bits.
  - Channel c, 0..2.
- Byte select:
  - pixel_data_o = word_q[32*p[2:0] + 8*c +: 8].
- Address:
  - mem_addr_o = (BASE_ADDR + p[11:3]) mod 512. The address wraps; no error is flagged.
- IDLE:
  - If trigger=1 and W≠0, latch W and go to FETCH.
  - If trigger=1 and W=0, go to DONE.
- FETCH:
  - mem_rd_o=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - Capture mem_data_i into word_q, then go to STREAM.
- STREAM:
  - pixel_valid_o=1. A transfer occurs when valid & ready.
  - On transfer, advance c; on c=2, set c=0 and p+1.
  - After the last byte (p=W-1, c=2), go to DONE.
  - When p[2:0]=7 and c=2 with more pixels remaining, go to FETCH.
- DONE:
  - pixel_trigger_done_o=1. Stay here while trigger is high.
- Trigger low in any state:
  - Next cycle is IDLE; valid, done and rd are all 0; p and c are cleared.
  - A new line requires trigger low then high.
- Handshake:
  - pixel_data_o is stable while valid & !ready.
  - Valid never drops without a transfer, except on abort or reset.
- Reset values:
  - All outputs are 0. mem_addr_o = BASE_ADDR. State is IDLE.
- Reset mid-line:
  - Identical to abort, effective next cycle.

## Timing
- Let trigger be sampled high at the end of cycle 0.
  - Cycle 1: mem_rd_o=1, addr=BASE_ADDR.
  - Cycle 2: data captured.
  - Cycle 3: first valid byte (R of pixel 0).
- Steady state is 1 byte per cycle while ready is high, i.e. 24 bytes per SRAM read.
- Word boundary without prefetch:
  - 2 bubble cycles (FETCH, WAIT) between byte 23 and byte 24 of consecutive words.
- DONE timing:
  - The last transfer at the end of cycle n gives valid=0 and done=1 in cycle n+1.
  - With W=0, done=1 in cycle 1 and no read is issued.
- All outputs are registered.

## Configuration
- Macro: PIXEL_UNPACK_PREFETCH_EN.
- Defined:
  - A shadow register plus shadow-valid flag is added.
  - In the first STREAM cycle of each word, if pixels remain beyond the current word, one read of the next address is issued and captured into the shadow register.
  - At the word boundary the shadow is swapped in: zero bubbles, and backpressure has no effect on the prefetch.
  - At most one outstanding prefetch.
  - Abort or reset clears the shadow-valid flag.
- Undefined:
  - Single word register with the 2-cycle word-boundary bubble.
  - Read count and address order are identical in both builds.

## Test plan
- W=8, BASE=0, slot k = {8'hDD, 3k+2, 3k+1, 3k}, ready=1:
  - Bytes 0x00..0x17 appear in cycles 3..26, with no 0xDD.
  - Exactly one read, at address 0.
  - done=1 in cycle 27.
- W=10, ready=1:
  - 30 bytes; reads at addresses 0 and 1.
  - Without the macro, a 2-cycle gap after byte 23.
  - With the macro, no gap, and the second read is issued while word 0 streams.
- W=16, ready randomly toggled at 50%:
  - Byte order is preserved and data is stable during every stall.
  - done asserts exactly once, after byte 47.
- W=0:
  - done=1 in cycle 1; no mem_rd_o and no valid ever.
- W=12:
  - Drop trigger after 5 transfers: valid=0 the next cycle.
  - Retrigger: reads restart at BASE_ADDR and the first byte is pixel 0 R.
  - Repeat the sequence using rst instead of trigger, with identical results.
- W=4095, BASE_ADDR=9'h1F0:
  - Addresses run 0x1F0..0x1FF, 0x000..0x1EF (512 reads).
  - 12285 bytes are emitted, and the last byte is the B of slot 6 of word 0x1EF.

Source files
------------

// File: rtl/pixel_unpacker_if.sv
// pixel_unpacker_if: groups the line-SRAM read port, the line control
// signals and the byte-serial pixel stream of pixel_unpacker.
// The master modport is the unpacker side; the slave modport is the
// environment (SRAM plus downstream consumer plus line sequencer).

`ifndef SRAM_WIDTH
`define SRAM_WIDTH 256
`endif

interface pixel_unpacker_if;
   logic                   pixel_trigger_i;
   logic [11:0]            image_width_i;
   logic                   mem_rd_o;
   logic [8:0]             mem_addr_o;
   logic [`SRAM_WIDTH-1:0] mem_data_i;
   logic [7:0]             pixel_data_o;
   logic                   pixel_valid_o;
   logic                   pixel_ready_i;
   logic                   pixel_trigger_done_o;

   modport master (
      input  pixel_trigger_i, image_width_i, mem_data_i, pixel_ready_i,
      output mem_rd_o, mem_addr_o, pixel_data_o, pixel_valid_o, pixel_trigger_done_o
   );

   modport slave (
      output pixel_trigger_i, image_width_i, mem_data_i, pixel_ready_i,
      input  mem_rd_o, mem_addr_o, pixel_data_o, pixel_valid_o, pixel_trigger_done_o
   );
endinterface

// File: rtl/pixel_unpacker.sv
// pixel_unpacker: reads 256-bit line-SRAM words (8 pixels, 32-bit slots
// R,G,B,dummy) and streams R,G,B bytes under valid/ready.
// Optional macro PIXEL_UNPACK_PREFETCH_EN adds a shadow word register that
// prefetches the next SRAM word so word boundaries cost no bubble cycles.
// All outputs come straight from flops; they are computed from next-state
// values so valid, data and the read strobe line up with the FSM state.

`ifndef SRAM_WIDTH
`define SRAM_WIDTH 256
`endif

module pixel_unpacker #(
   parameter logic [8:0] BASE_ADDR = 9'd0
) (
   input  logic             clk,
   input  logic             rst,
   pixel_unpacker_if.master bus
);
   localparam int SW = `SRAM_WIDTH;

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, STREAM, DONE} state_t;

   state_t        state_q, state_n;
   logic [11:0]   p_q, p_n;
   logic [11:0]   w_q, w_n;
   logic [1:0]    c_q, c_n;
   logic [SW-1:0] word_q, word_n;
   logic          rd_n;
   logic          pf_n;
   logic          xfer;
   logic          last_px;

   logic [7:0]    data_q;
   logic          vld_q;
   logic          done_q;
   logic          rd_q;
   logic [8:0]    addr_q;

`ifdef PIXEL_UNPACK_PREFETCH_EN
   logic [SW-1:0] shadow_q;
   logic          shadow_vld_q;
   logic          pf_rd_q;
   logic          pf_cap_q;
   logic          take_shadow;
`endif

   // Byte lane of pixel slot 'slot', channel 'c' (0=R,1=G,2=B)
   function automatic logic [7:0] sel_byte(input logic [SW-1:0] wd,
                                           input logic [2:0]    slot,
                                           input logic [1:0]    c);
      logic [7:0] idx;
      idx = {slot, 5'd0} + {3'd0, c, 3'd0};
      return wd[idx +: 8];
   endfunction

`ifdef PIXEL_UNPACK_PREFETCH_EN
   // True when the line extends beyond the word whose index is 'word_idx'
   function automatic logic more_after(input logic [8:0]  word_idx,
                                       input logic [11:0] width);
      return {1'b0, width} > ({1'b0, word_idx, 3'd0} + 13'd8);
   endfunction
`endif

   assign bus.mem_rd_o             = rd_q;
   assign bus.mem_addr_o           = addr_q;
   assign bus.pixel_data_o         = data_q;
   assign bus.pixel_valid_o        = vld_q;
   assign bus.pixel_trigger_done_o = done_q;

   // Next-state, counter and word-register selection; trigger low overrides all
   always_comb begin
      state_n = state_q;
      p_n     = p_q;
      c_n     = c_q;
      w_n     = w_q;
      word_n  = word_q;
      rd_n    = 1'b0;
      pf_n    = 1'b0;
`ifdef PIXEL_UNPACK_PREFETCH_EN
      take_shadow = 1'b0;
`endif
      xfer    = (state_q == STREAM) && bus.pixel_ready_i;
      last_px = (p_q == w_q - 12'd1);

      case (state_q)
         IDLE: begin
            if (bus.pixel_trigger_i) begin
               p_n = 12'd0;
               c_n = 2'd0;
               if (bus.image_width_i != 12'd0) begin
                  w_n     = bus.image_width_i;
                  state_n = FETCH;
                  rd_n    = 1'b1;
               end else begin
                  state_n = DONE;
               end
            end
         end
         FETCH: state_n = WAIT;
         WAIT: begin
            word_n  = bus.mem_data_i;
            state_n = STREAM;
`ifdef PIXEL_UNPACK_PREFETCH_EN
            pf_n    = more_after(p_q[11:3], w_q);
`endif
         end
         STREAM: begin
            if (xfer) begin
               if (c_q == 2'd2) begin
                  c_n = 2'd0;
                  p_n = p_q + 12'd1;
                  if (last_px) begin
                     state_n = DONE;
                  end else if (p_q[2:0] == 3'd7) begin
`ifdef PIXEL_UNPACK_PREFETCH_EN
                     if (shadow_vld_q) begin
                        word_n      = shadow_q;
                        take_shadow = 1'b1;
                        pf_n        = more_after(p_n[11:3], w_q);
                     end else begin
                        state_n = FETCH;
                        rd_n    = 1'b1;
                     end
`else
                     state_n = FETCH;
                     rd_n    = 1'b1;
`endif
                  end
               end else begin
                  c_n = c_q + 2'd1;
               end
            end
         end
         DONE:    state_n = DONE;
         default: state_n = IDLE;
      endcase

      if (!bus.pixel_trigger_i) begin
         state_n = IDLE;
         p_n     = 12'd0;
         c_n     = 2'd0;
         rd_n    = 1'b0;
         pf_n    = 1'b0;
`ifdef PIXEL_UNPACK_PREFETCH_EN
         take_shadow = 1'b0;
`endif
      end
   end

   // Control state and registered outputs, all derived from next-state values
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         p_q     <= 12'd0;
         c_q     <= 2'd0;
         w_q     <= 12'd0;
         vld_q   <= 1'b0;
         done_q  <= 1'b0;
         rd_q    <= 1'b0;
         addr_q  <= BASE_ADDR;
         data_q  <= 8'd0;
      end else begin
         state_q <= state_n;
         p_q     <= p_n;
         c_q     <= c_n;
         w_q     <= w_n;
         vld_q   <= (state_n == STREAM);
         done_q  <= (state_n == DONE);
         rd_q    <= rd_n | pf_n;
         addr_q  <= BASE_ADDR + p_n[11:3] + {8'd0, pf_n};
         data_q  <= (state_n == STREAM) ? sel_byte(word_n, p_n[2:0], c_n) : 8'd0;
      end
   end

   // Current word holding register (data path, no reset needed)
   always_ff @(posedge clk) begin
      word_q <= word_n;
   end

`ifdef PIXEL_UNPACK_PREFETCH_EN
   // Prefetch tracking: read issued, data due next cycle, shadow holds next word
   always_ff @(posedge clk) begin
      if (rst || !bus.pixel_trigger_i) begin
         pf_rd_q      <= 1'b0;
         pf_cap_q     <= 1'b0;
         shadow_vld_q <= 1'b0;
      end else begin
         pf_rd_q  <= pf_n;
         pf_cap_q <= pf_rd_q;
         if (pf_cap_q) begin
            shadow_vld_q <= 1'b1;
         end else if (take_shadow) begin
            shadow_vld_q <= 1'b0;
         end
      end
   end

   // Shadow word capture, one cycle after the prefetch strobe
   always_ff @(posedge clk) begin
      if (pf_cap_q) begin
         shadow_q <= bus.mem_data_i;
      end
   end
`endif

endmodule

// File: tb/tb_pixel_unpacker.sv
// tb_pixel_unpacker: two unpackers (BASE_ADDR 0 and 9'h1F0) run in lockstep
// on shared control inputs, each with its own SRAM model. Slot k of the
// word at relative index i holds bytes 24i+3k+{0,1,2} (mod 256) and 0xDD,
// so byte n of a line is simply n mod 256. Expected bytes and read
// addresses are queued before each line; monitors pop and compare.

module tb_pixel_unpacker;
`ifdef PIXEL_UNPACK_PREFETCH_EN
   localparam bit PF_ON = 1'b1;
`else
   localparam bit PF_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        trig;
   logic        ready;
   logic [11:0] width;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   logic [7:0] eb0[$];
   logic [7:0] eb1[$];
   logic [8:0] ea0[$];
   logic [8:0] ea1[$];

   logic       stall0 = 1'b0, stall1 = 1'b0;
   logic [7:0] hold0, hold1;
   logic [7:0] last_b1;
   logic [8:0] last_a0, last_a1;

   int first_cyc, done_cyc, done_edges, n_xfer, xfer_at_done, max_gap;
   int rd_cyc[$];
   logic vld8_0, vld8_1, done_hold;

   pixel_unpacker_if if0 ();
   pixel_unpacker_if if1 ();

   assign if0.pixel_trigger_i = trig;
   assign if0.image_width_i   = width;
   assign if0.pixel_ready_i   = ready;
   assign if1.pixel_trigger_i = trig;
   assign if1.image_width_i   = width;
   assign if1.pixel_ready_i   = ready;

   pixel_unpacker #(.BASE_ADDR(9'h000)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   pixel_unpacker #(.BASE_ADDR(9'h1F0)) dut1 (.clk(clk), .rst(rst), .bus(if1));

   always #5 clk = ~clk;

   function automatic logic [255:0] make_word(input logic [8:0] rel);
      logic [255:0] wd;
      for (int k = 0; k < 8; k++) begin
         wd[32*k +: 8]    = 8'((24*int'(rel) + 3*k)     & 255);
         wd[32*k+8 +: 8]  = 8'((24*int'(rel) + 3*k + 1) & 255);
         wd[32*k+16 +: 8] = 8'((24*int'(rel) + 3*k + 2) & 255);
         wd[32*k+24 +: 8] = 8'hDD;
      end
      return wd;
   endfunction

   // SRAM models: data valid the cycle after the read strobe, junk otherwise
   always @(posedge clk) begin
      if (if0.mem_rd_o) if0.mem_data_i <= make_word(if0.mem_addr_o);
      else              if0.mem_data_i <= {32{8'hEE}};
      if (if1.mem_rd_o) if1.mem_data_i <= make_word(9'(if1.mem_addr_o - 9'h1F0));
      else              if1.mem_data_i <= {32{8'hEE}};
   end

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic unexpected(input string name, input int act);
      checks++;
      errors++;
      $display("FAIL %s actual=%0h required=nothing", name, act);
   endtask

   // Monitor for the BASE_ADDR=0 instance
   always @(negedge clk) begin
      if (mon_en) begin
         if (stall0) begin
            check("stall_valid0", int'(if0.pixel_valid_o), 1);
            check("stall_data0", int'(if0.pixel_data_o), int'(hold0));
         end
         if (if0.pixel_valid_o && ready) begin
            if (eb0.size() == 0) unexpected("extra_byte0", int'(if0.pixel_data_o));
            else check("byte0", int'(if0.pixel_data_o), int'(eb0.pop_front()));
         end
         if (if0.mem_rd_o) begin
            last_a0 = if0.mem_addr_o;
            if (ea0.size() == 0) unexpected("extra_read0", int'(if0.mem_addr_o));
            else check("read_addr0", int'(if0.mem_addr_o), int'(ea0.pop_front()));
         end
         stall0 = if0.pixel_valid_o && !ready && trig && !rst;
         hold0  = if0.pixel_data_o;
      end
   end

   // Monitor for the BASE_ADDR=9'h1F0 instance
   always @(negedge clk) begin
      if (mon_en) begin
         if (stall1) begin
            check("stall_valid1", int'(if1.pixel_valid_o), 1);
            check("stall_data1", int'(if1.pixel_data_o), int'(hold1));
         end
         if (if1.pixel_valid_o && ready) begin
            last_b1 = if1.pixel_data_o;
            if (eb1.size() == 0) unexpected("extra_byte1", int'(if1.pixel_data_o));
            else check("byte1", int'(if1.pixel_data_o), int'(eb1.pop_front()));
         end
         if (if1.mem_rd_o) begin
            last_a1 = if1.mem_addr_o;
            if (ea1.size() == 0) unexpected("extra_read1", int'(if1.mem_addr_o));
            else check("read_addr1", int'(if1.mem_addr_o), int'(ea1.pop_front()));
         end
         stall1 = if1.pixel_valid_o && !ready && trig && !rst;
         hold1  = if1.pixel_data_o;
      end
   end

   // abort_kind: 0 = full line, 1 = drop trigger in cycle 7, 2 = rst in cycle 7
   task automatic run_line(input int w, input bit rnd, input int abort_kind);
      int nb, nr, last_x;
      bit prev_done;
      if (abort_kind != 0) begin
         nb = 5;
         nr = PF_ON ? 2 : 1;
      end else begin
         nb = 3 * w;
         nr = (w + 7) / 8;
      end
      for (int i = 0; i < nb; i++) begin
         eb0.push_back(8'(i & 255));
         eb1.push_back(8'(i & 255));
      end
      for (int r = 0; r < nr; r++) begin
         ea0.push_back(9'(r));
         ea1.push_back(9'(9'h1F0 + r));
      end
      first_cyc = -1; done_cyc = -1; done_edges = 0; n_xfer = 0;
      xfer_at_done = -1; max_gap = 0; last_x = -1; prev_done = 1'b0;
      vld8_0 = 1'b1; vld8_1 = 1'b1; done_hold = 1'b0;
      rd_cyc.delete();

      @(posedge clk); #1;
      width = 12'(w);
      trig  = 1'b1;
      ready = 1'b1;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         @(negedge clk);
         if (if0.mem_rd_o) rd_cyc.push_back(cyc);
         if (if0.pixel_valid_o && first_cyc < 0) first_cyc = cyc;
         if (if0.pixel_valid_o && ready) begin
            if (last_x >= 0 && cyc - last_x - 1 > max_gap) max_gap = cyc - last_x - 1;
            last_x = cyc;
            n_xfer++;
         end
         if (if0.pixel_trigger_done_o && !prev_done) begin
            done_edges++;
            if (done_cyc < 0) begin
               done_cyc     = cyc;
               xfer_at_done = n_xfer;
            end
         end
         prev_done = if0.pixel_trigger_done_o;
         if (cyc == 8) begin
            vld8_0 = if0.pixel_valid_o;
            vld8_1 = if1.pixel_valid_o;
         end
         if (abort_kind == 0 && done_cyc >= 0 && cyc >= done_cyc + 3) begin
            done_hold = if0.pixel_trigger_done_o;
            break;
         end
         @(posedge clk); #1;
         if (rnd) ready = 1'($urandom_range(0, 1));
         if (abort_kind != 0 && cyc == 6) begin
            if (abort_kind == 1) trig = 1'b0;
            else                 rst  = 1'b1;
         end
         if (abort_kind != 0 && cyc == 8) break;
      end
      @(posedge clk); #1;
      trig  = 1'b0;
      rst   = 1'b0;
      ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("bytes_left0", eb0.size(), 0);
      check("bytes_left1", eb1.size(), 0);
      check("reads_left0", ea0.size(), 0);
      check("reads_left1", ea1.size(), 0);
   endtask

   initial begin
      rst   = 1'b1;
      trig  = 1'b0;
      ready = 1'b1;
      width = 12'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid0", int'(if0.pixel_valid_o), 0);
      check("rst_done0",  int'(if0.pixel_trigger_done_o), 0);
      check("rst_rd0",    int'(if0.mem_rd_o), 0);
      check("rst_data0",  int'(if0.pixel_data_o), 0);
      check("rst_addr0",  int'(if0.mem_addr_o), 'h000);
      check("rst_valid1", int'(if1.pixel_valid_o), 0);
      check("rst_addr1",  int'(if1.mem_addr_o), 'h1F0);
      @(posedge clk); #1;
      rst    = 1'b0;
      mon_en = 1'b1;
      repeat (2) @(posedge clk);

      // One full word, ready held high
      run_line(8, 1'b0, 0);
      check("w8_first_cycle", first_cyc, 3);
      check("w8_done_cycle", done_cyc, 27);
      check("w8_xfers", n_xfer, 24);
      check("w8_reads", rd_cyc.size(), 1);
      check("w8_rd_cycle", rd_cyc.size() > 0 ? rd_cyc[0] : -1, 1);
      check("w8_gap", max_gap, 0);
      check("w8_done_edges", done_edges, 1);
      check("w8_done_hold", int'(done_hold), 1);

      // Word boundary: bubble without prefetch, none with it
      run_line(10, 1'b0, 0);
      check("w10_xfers", n_xfer, 30);
      check("w10_reads", rd_cyc.size(), 2);
      check("w10_rd1_cycle", rd_cyc.size() > 1 ? rd_cyc[1] : -1, PF_ON ? 3 : 27);
      check("w10_gap", max_gap, PF_ON ? 0 : 2);
      check("w10_done_cycle", done_cyc, PF_ON ? 33 : 35);

      // Random backpressure
      run_line(16, 1'b1, 0);
      check("w16_xfers", n_xfer, 48);
      check("w16_xfer_at_done", xfer_at_done, 48);
      check("w16_done_edges", done_edges, 1);

      // Zero width
      run_line(0, 1'b0, 0);
      check("w0_done_cycle", done_cyc, 1);
      check("w0_reads", rd_cyc.size(), 0);
      check("w0_first_valid", first_cyc, -1);

      // Abort via trigger, then retrigger
      run_line(12, 1'b0, 1);
      check("abt_xfers", n_xfer, 5);
      check("abt_valid_next0", int'(vld8_0), 0);
      check("abt_valid_next1", int'(vld8_1), 0);
      run_line(12, 1'b0, 0);
      check("abt_re_first_cycle", first_cyc, 3);
      check("abt_re_rd_cycle", rd_cyc.size() > 0 ? rd_cyc[0] : -1, 1);
      check("abt_re_xfers", n_xfer, 36);

      // Abort via reset, then retrigger
      run_line(12, 1'b0, 2);
      check("rst_abt_xfers", n_xfer, 5);
      check("rst_abt_valid_next0", int'(vld8_0), 0);
      check("rst_abt_valid_next1", int'(vld8_1), 0);
      run_line(12, 1'b0, 0);
      check("rst_re_first_cycle", first_cyc, 3);
      check("rst_re_rd_cycle", rd_cyc.size() > 0 ? rd_cyc[0] : -1, 1);
      check("rst_re_xfers", n_xfer, 36);

      // Maximum width, address wrap on the 9'h1F0 instance
      run_line(4095, 1'b0, 0);
      check("wmax_xfers", n_xfer, 12285);
      check("wmax_reads", rd_cyc.size(), 512);
      check("wmax_last_byte1", int'(last_b1), 'hFC);
      check("wmax_last_addr1", int'(last_a1), 'h1EF);
      check("wmax_last_addr0", int'(last_a0), 'h1FF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
